feedback: RTL and testbench
===========================

// Module: feedback
//
// PURPOSE
// - Mastermind-style scorer: compares the 4-peg guess (history0..3) against the
//   4-peg secret (code0..3) and produces one 2-bit hint per peg position.
// - The hints drive the four seven-segment digits, and game_over goes to the
//   game controller.
// - Sits between the guess-history register file and the SSD display driver.
//   All outputs are registered.
//
// PARAMETERS
// - none (peg count fixed at 4; colour width fixed at 3 bits, 8 colours)
//
// PORTS
// - clk        in   1  system clock; all logic on posedge
// - rst        in   1  reset; synchronous, active-high
// - last_turn  in   1  high while the current guess is the final allowed turn
// - code0..3   in   3  secret colour for peg positions 0..3
// - history0..3 in  3  guessed colour for peg positions 0..3
// - ssd0..3    out  2  hint for peg position 0..3
// - game_over  out  1  game finished (win, or last turn used)
//
// BEHAVIOUR
// - Hint encoding:
//   - 2'd0 = colour absent
//   - 2'd1 = colour present, wrong position
//   - 2'd2 = exact match
//   - 2'd3 = never driven
// - Reset (rst=1 at posedge): ssd0..3 <= 0 and game_over <= 0. Reset overrides
//   scoring in the same cycle.
// - Latency: all inputs are sampled at a posedge. ssd*/game_over reflect those
//   inputs after that edge (1 cycle). Inputs are re-scored every cycle; there is
//   no handshake and no enable.
// - Scoring is combinational, evaluated in two passes:
//   - Pass 1, exact: exact[i] = (history_i == code_i). An exact peg consumes
//     code peg i.
//   - Pass 2, present: process i = 0,1,2,3 in order. This pass is skipped for
//     any i with exact[i] set.
//   - For each such i, search j = 0..3 for a code peg j that is not exact[j],
//     not already consumed, and has code_j == history_i.
//   - If found, hint i = 1 and code peg j is consumed (lowest such j). If not
//     found, hint i = 0.
// - Multiplicity rule: each code peg satisfies at most one guess peg. The number
//   of 1/2 hints for a colour never exceeds that colour's count in the code.
//   Duplicate guess colours beyond that count get 0, leftmost positions having
//   priority.
// - game_over <= (all four exact) | last_turn. It is not sticky: it is
//   re-evaluated every cycle, and the controller latches it if required.
// - Colour value 0 is an ordinary colour, not "empty".
// - No internal state other than the output registers.
//
// TESTING
// - code=0,1,2,3, history=0,0,0,0, last_turn=0
//   -> next cycle ssd=2-0-0-0, game_over=0. Code peg 0 is consumed by the exact
//   match, so the other guess 0s do not score.
// - Same code, history=0,1,0,0 then 0,1,2,0 then 0,1,2,3 (one change per cycle)
//   -> ssd=2-2-0-0, then 2-2-2-0, then 2-2-2-2 with game_over=1, each one cycle
//   after the change.
// - code=0,1,2,3, history=3,2,1,0 -> ssd=1-1-1-1, game_over=0; then raise
//   last_turn=1 -> game_over=1 next cycle with ssd unchanged.
// - code=5,5,1,2, history=5,1,5,5 -> ssd=2-1-1-0. Only two 5s exist in the
//   code, so the last guess 5 gets 0.
// - code=7,6,6,6, history=6,7,7,7 -> ssd=1-1-0-0.
// - Apply rst=1 mid-game with matching inputs -> ssd=0-0-0-0 and game_over=0
//   after that edge. Release rst -> scoring resumes next cycle.

Source files
------------

// File: rtl/feedback_if.sv
// Guess/secret/hint bundle between the game datapath and the Mastermind scorer.
// The master drives the pegs and last_turn. The slave (scorer) returns hints and game_over.
interface feedback_if;
  logic       last_turn;
  logic [2:0] code0, code1, code2, code3;
  logic [2:0] history0, history1, history2, history3;
  logic [1:0] ssd0, ssd1, ssd2, ssd3;
  logic       game_over;

  modport master (
    output last_turn,
    output code0, code1, code2, code3,
    output history0, history1, history2, history3,
    input  ssd0, ssd1, ssd2, ssd3,
    input  game_over
  );

  modport slave (
    input  last_turn,
    input  code0, code1, code2, code3,
    input  history0, history1, history2, history3,
    output ssd0, ssd1, ssd2, ssd3,
    output game_over
  );
endinterface

// File: rtl/feedback.sv
// Mastermind scorer: a per-peg hint (0 absent, 1 misplaced, 2 exact) plus game_over.
// Scoring is combinational. Every output is registered, with a synchronous active-high reset.
module feedback (
  input  logic        clk,
  input  logic        rst,
  feedback_if.slave   fb
);

  logic [2:0] code_a [4];
  logic [2:0] hist_a [4];

  assign code_a[0] = fb.code0;
  assign code_a[1] = fb.code1;
  assign code_a[2] = fb.code2;
  assign code_a[3] = fb.code3;
  assign hist_a[0] = fb.history0;
  assign hist_a[1] = fb.history1;
  assign hist_a[2] = fb.history2;
  assign hist_a[3] = fb.history3;

  logic [3:0]      exact;
  logic [3:0]      used;
  logic            found;
  logic [3:0][1:0] ssd_d, ssd_q;
  logic            game_over_d, game_over_q;

  // NOTE: blocking assignments are used here because each loop iteration must see
  // what earlier iterations consumed. Every variable gets a default first, so no latches are inferred.
  always_comb begin
    exact = '0;
    used  = '0;
    found = 1'b0;
    ssd_d = '0;

    for (int i = 0; i < 4; i++) begin
      if (hist_a[i] == code_a[i]) begin
        exact[i] = 1'b1;
        used[i]  = 1'b1;
        ssd_d[i] = 2'd2;
      end
    end

    // Misplaced pass. Guess pegs are taken left to right, and each claims the lowest free matching code peg.
    for (int i = 0; i < 4; i++) begin
      if (!exact[i]) begin
        found = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!found && !used[j] && (code_a[j] == hist_a[i])) begin
            found    = 1'b1;
            used[j]  = 1'b1;
            ssd_d[i] = 2'd1;
          end
        end
      end
    end

    game_over_d = (&exact) | fb.last_turn;
  end

  // NOTE: sequential state uses non-blocking assignments only. The reset is synchronous,
  // so it is tested inside the clocked block and takes priority over the freshly scored values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ssd_q       <= '0;
      game_over_q <= 1'b0;
    end else begin
      ssd_q       <= ssd_d;
      game_over_q <= game_over_d;
    end
  end

  assign fb.ssd0      = ssd_q[0];
  assign fb.ssd1      = ssd_q[1];
  assign fb.ssd2      = ssd_q[2];
  assign fb.ssd3      = ssd_q[3];
  assign fb.game_over = game_over_q;

endmodule

// File: tb/tb_feedback.sv
// Self-checking bench for the feedback scorer. It runs directed cases and then random vectors
// against a colour-count reference model.
module tb_feedback;

  typedef logic [2:0] pegs_t [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  feedback_if fb_if ();

  feedback u_dut (
    .clk (clk),
    .rst (rst),
    .fb  (fb_if.slave)
  );

  always #5 clk = ~clk;

  // Hints packed in display order {peg0, peg1, peg2, peg3}.
  function automatic logic [7:0] observed_hints();
    return {fb_if.ssd0, fb_if.ssd1, fb_if.ssd2, fb_if.ssd3};
  endfunction

  // Reference model. Exact pegs are settled first. Each colour then has a budget equal to the number of
  // non-exact code pegs of that colour. Guess pegs spend that budget left to right.
  function automatic logic [8:0] model(pegs_t c, pegs_t h, logic lt);
    int         budget [8];
    logic [1:0] hint   [4];
    int         n_exact = 0;
    for (int k = 0; k < 8; k++) budget[k] = 0;
    for (int i = 0; i < 4; i++) begin
      if (h[i] == c[i]) n_exact++;
      else budget[c[i]]++;
    end
    for (int i = 0; i < 4; i++) begin
      if (h[i] == c[i]) hint[i] = 2'd2;
      else if (budget[h[i]] > 0) begin
        hint[i] = 2'd1;
        budget[h[i]]--;
      end else hint[i] = 2'd0;
    end
    return {hint[0], hint[1], hint[2], hint[3], (n_exact == 4) || lt};
  endfunction

  // Drive the inputs just after a posedge, then move on to 1 ns after the edge that samples them.
  task automatic drive(pegs_t c, pegs_t h, logic lt);
    fb_if.code0 = c[0]; fb_if.code1 = c[1]; fb_if.code2 = c[2]; fb_if.code3 = c[3];
    fb_if.history0 = h[0]; fb_if.history1 = h[1];
    fb_if.history2 = h[2]; fb_if.history3 = h[3];
    fb_if.last_turn = lt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pegs_t c = '{3'd0, 3'd1, 3'd2, 3'd3};
    rst = 1'b1;
    drive(c, c, 1'b1);
    vectors++;
    if ({observed_hints(), fb_if.game_over} !== 9'b0) begin
      $display("FAIL reset: got ssd=%b go=%b, want ssd=00000000 go=0",
               observed_hints(), fb_if.game_over);
      miscompares++;
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    pegs_t      c [9];
    pegs_t      h [9];
    logic       lt  [9];
    logic [8:0] exp [9];
    logic [8:0] got;
    c[0] = '{0,1,2,3}; h[0] = '{0,0,0,0}; lt[0] = 0; exp[0] = {8'b10_00_00_00, 1'b0};
    c[1] = '{0,1,2,3}; h[1] = '{0,1,0,0}; lt[1] = 0; exp[1] = {8'b10_10_00_00, 1'b0};
    c[2] = '{0,1,2,3}; h[2] = '{0,1,2,0}; lt[2] = 0; exp[2] = {8'b10_10_10_00, 1'b0};
    c[3] = '{0,1,2,3}; h[3] = '{0,1,2,3}; lt[3] = 0; exp[3] = {8'b10_10_10_10, 1'b1};
    c[4] = '{0,1,2,3}; h[4] = '{3,2,1,0}; lt[4] = 0; exp[4] = {8'b01_01_01_01, 1'b0};
    c[5] = '{0,1,2,3}; h[5] = '{3,2,1,0}; lt[5] = 1; exp[5] = {8'b01_01_01_01, 1'b1};
    c[6] = '{5,5,1,2}; h[6] = '{5,1,5,5}; lt[6] = 0; exp[6] = {8'b10_01_01_00, 1'b0};
    c[7] = '{7,6,6,6}; h[7] = '{6,7,7,7}; lt[7] = 0; exp[7] = {8'b01_01_00_00, 1'b0};
    c[8] = '{4,4,4,4}; h[8] = '{4,4,4,4}; lt[8] = 1; exp[8] = {8'b10_10_10_10, 1'b1};
    for (int v = 0; v < 9; v++) begin
      drive(c[v], h[v], lt[v]);
      got = {observed_hints(), fb_if.game_over};
      vectors++;
      if (got !== exp[v]) begin
        $display("FAIL directed[%0d]: got ssd=%b go=%b, want ssd=%b go=%b",
                 v, got[8:1], got[0], exp[v][8:1], exp[v][0]);
        miscompares++;
      end
    end
  endtask

  task automatic test_mid_reset();
    pegs_t      c = '{6, 2, 2, 7};
    logic [8:0] got;
    rst = 1'b1;
    drive(c, c, 1'b0);
    got = {observed_hints(), fb_if.game_over};
    vectors++;
    if (got !== 9'b0) begin
      $display("FAIL mid_reset: got ssd=%b go=%b, want ssd=00000000 go=0", got[8:1], got[0]);
      miscompares++;
    end
    rst = 1'b0;
    drive(c, c, 1'b0);
    got = {observed_hints(), fb_if.game_over};
    vectors++;
    if (got !== {8'b10_10_10_10, 1'b1}) begin
      $display("FAIL reset_release: got ssd=%b go=%b, want ssd=10101010 go=1", got[8:1], got[0]);
      miscompares++;
    end
  endtask

  // A new random vector every cycle. A narrow colour range forces duplicates, and some vectors are wins.
  task automatic test_back_to_back_random();
    pegs_t      c, h;
    logic       lt;
    logic [8:0] exp, got;
    int         max_col;
    for (int v = 0; v < 400; v++) begin
      max_col = (v % 2 == 0) ? 7 : 2;
      for (int i = 0; i < 4; i++) begin
        c[i] = 3'($urandom_range(max_col, 0));
        h[i] = 3'($urandom_range(max_col, 0));
      end
      if ($urandom_range(9, 0) == 0) h = c;
      lt  = ($urandom_range(7, 0) == 0);
      exp = model(c, h, lt);
      drive(c, h, lt);
      got = {observed_hints(), fb_if.game_over};
      vectors++;
      if (got !== exp) begin
        $display("FAIL random[%0d]: code=%0d%0d%0d%0d hist=%0d%0d%0d%0d lt=%b got ssd=%b go=%b, want ssd=%b go=%b",
                 v, c[0], c[1], c[2], c[3], h[0], h[1], h[2], h[3], lt,
                 got[8:1], got[0], exp[8:1], exp[0]);
        miscompares++;
      end
    end
  endtask

  initial begin
    fb_if.code0 = 0; fb_if.code1 = 0; fb_if.code2 = 0; fb_if.code3 = 0;
    fb_if.history0 = 0; fb_if.history1 = 0; fb_if.history2 = 0; fb_if.history3 = 0;
    fb_if.last_turn = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_mid_reset();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
